// File: rtl/dtree_feature_loader.sv
// Feature loader ahead of the arrhythmia decision tree: captures seven selected
// beats of a serial record and holds them as one parallel frame until accepted.
module dtree_feature_loader #(
  parameter int RECORD_LEN = 280,
  parameter int IDX_W      = 9,
  parameter int SEL0       = 6,
  parameter int SEL1       = 13,
  parameter int SEL2       = 169,
  parameter int SEL3       = 236,
  parameter int SEL4       = 251,
  parameter int SEL5       = 260,
  parameter int SEL6       = 278
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  f0,
  output logic [7:0]  f1,
  output logic [7:0]  f2,
  output logic [7:0]  f3,
  output logic [7:0]  f4,
  output logic [7:0]  f5,
  output logic [7:0]  f6,
  output logic        err,
  output logic [15:0] frame_cnt
);

  localparam int NFEAT = 7;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RECORD_LEN - 1);

  typedef enum logic [1:0] {COLLECT, HOLD, SKIP} state_t;

  state_t                     state_q;
  logic [IDX_W-1:0]           idx_q;
  logic [IDX_W-1:0]           idx_d;
  logic [NFEAT-1:0][7:0]      f_q;
  logic                       s_ready_q;
  logic                       m_valid_q;
  logic                       err_q;
  logic [15:0]                cnt_q;

  logic                       accept;
  logic                       at_end;
  logic [NFEAT-1:0]           hit;

  assign accept = s_valid & s_ready_q;
  assign at_end = (idx_q == LAST_IDX);
  assign idx_d  = idx_q + 1'b1;

  // Several selectors may name the same index; every matching slot captures.
  always_comb begin
    hit    = '0;
    hit[0] = (idx_q == IDX_W'(SEL0));
    hit[1] = (idx_q == IDX_W'(SEL1));
    hit[2] = (idx_q == IDX_W'(SEL2));
    hit[3] = (idx_q == IDX_W'(SEL3));
    hit[4] = (idx_q == IDX_W'(SEL4));
    hit[5] = (idx_q == IDX_W'(SEL5));
    hit[6] = (idx_q == IDX_W'(SEL6));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      idx_q     <= '0;
      f_q       <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        COLLECT: begin
          if (accept) begin
            for (int k = 0; k < NFEAT; k++)
              if (hit[k]) f_q[k] <= s_data;
            if (s_last) begin
              idx_q <= '0;
              if (at_end) begin
                state_q   <= HOLD;
                s_ready_q <= 1'b0;
                m_valid_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end else if (at_end) begin
              // Record overran its length: drop the rest up to s_last.
              idx_q   <= '0;
              err_q   <= 1'b1;
              state_q <= SKIP;
            end else begin
              idx_q <= idx_d;
            end
          end
        end
        HOLD: begin
          // Ready returns a cycle after the handshake; no m_ready->s_ready path.
          if (m_ready) begin
            state_q   <= COLLECT;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            cnt_q     <= cnt_q + 16'd1;
          end
        end
        SKIP: begin
          if (accept && s_last) begin
            state_q <= COLLECT;
            idx_q   <= '0;
          end
        end
        default: begin
          state_q   <= COLLECT;
          idx_q     <= '0;
          s_ready_q <= 1'b1;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign err       = err_q;
  assign frame_cnt = cnt_q;
  assign f0        = f_q[0];
  assign f1        = f_q[1];
  assign f2        = f_q[2];
  assign f3        = f_q[3];
  assign f4        = f_q[4];
  assign f5        = f_q[5];
  assign f6        = f_q[6];

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Bench for dtree_feature_loader: record-level queue model checked every cycle,
// plus literal expectations for the nominal frame and error pulse counts.
module tb_dtree_feature_loader;
  localparam int LEN = 280;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        m_ready = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, m_valid, err;
  logic [7:0]  f0, f1, f2, f3, f4, f5, f6;
  logic [15:0] frame_cnt;
  logic [7:0]  dut_f [7];

  dtree_feature_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .f0(f0), .f1(f1), .f2(f2), .f3(f3), .f4(f4), .f5(f5), .f6(f6),
    .err(err), .frame_cnt(frame_cnt)
  );

  assign dut_f[0] = f0;
  assign dut_f[1] = f1;
  assign dut_f[2] = f2;
  assign dut_f[3] = f3;
  assign dut_f[4] = f4;
  assign dut_f[5] = f5;
  assign dut_f[6] = f6;

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int errs = 0;

  // Reference model: a record is a queue of accepted beats, judged at its end.
  int         SEL [7] = '{6, 13, 169, 236, 251, 260, 278};
  logic [7:0] rec [$];
  logic [7:0] exp_f [7];
  bit         holding, skipping, f_clean, exp_err, chk_en;
  int         exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    exp_err = 1'b0;
    if (rst) begin
      holding = 0; skipping = 0; rec.delete(); f_clean = 1; exp_cnt = 0; chk_en = 1;
      for (int k = 0; k < 7; k++) exp_f[k] = 8'h00;
    end else if (holding) begin
      if (m_ready) begin
        holding = 0;
        exp_cnt = (exp_cnt + 1) % 65536;
      end
    end else if (s_valid) begin
      if (skipping) begin
        if (s_last) skipping = 0;
      end else begin
        rec.push_back(s_data);
        f_clean = 0;
        if (s_last) begin
          if (rec.size() == LEN) begin
            for (int k = 0; k < 7; k++) exp_f[k] = rec[SEL[k]];
            holding = 1;
          end else begin
            exp_err = 1'b1;
          end
          rec.delete();
        end else if (rec.size() == LEN) begin
          exp_err = 1'b1;
          skipping = 1;
          rec.delete();
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (err === 1'b1) errs++;
    if (chk_en) begin
      chk("s_ready", {31'd0, s_ready}, {31'd0, !holding});
      chk("m_valid", {31'd0, m_valid}, {31'd0, holding});
      chk("err", {31'd0, err}, {31'd0, exp_err});
      chk("frame_cnt", {16'd0, frame_cnt}, exp_cnt);
      if (holding || f_clean)
        for (int k = 0; k < 7; k++) chk($sformatf("f%0d", k), {24'd0, dut_f[k]}, {24'd0, exp_f[k]});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive n accepted beats; s_last on beat last_at (-1 = never).
  task automatic send_rec(input int n, input int last_at, input bit sparse, input bit rnd);
    int i, guard;
    logic [7:0] d;
    i = 0; guard = 0;
    d = rnd ? 8'($urandom) : 8'h00;
    while (i < n && guard < 4 * n + 100) begin
      bit v, acc;
      v = sparse ? 1'($urandom_range(0, 1)) : 1'b1;
      s_valid = v; s_data = d; s_last = (i == last_at);
      acc = v && s_ready;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        i++;
        d = rnd ? 8'($urandom) : 8'(i);
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("beats_sent", i, n);
  endtask

  task automatic take(input int stall);
    int w;
    w = 0;
    while (m_valid !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk("frame_ready", {31'd0, m_valid}, 32'd1);
    repeat (stall) begin @(posedge clk); #1; end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  task automatic check_idx_frame();
    chk("lit_f0", {24'd0, f0}, 32'h06);
    chk("lit_f1", {24'd0, f1}, 32'h0D);
    chk("lit_f2", {24'd0, f2}, 32'hA9);
    chk("lit_f3", {24'd0, f3}, 32'hEC);
    chk("lit_f4", {24'd0, f4}, 32'hFB);
    chk("lit_f5", {24'd0, f5}, 32'h04);
    chk("lit_f6", {24'd0, f6}, 32'h16);
  endtask

  initial begin
    int e0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_cnt", {16'd0, frame_cnt}, 32'd0);

    // Nominal record, data = index
    send_rec(LEN, LEN - 1, 0, 0);
    chk("nom_latency", {31'd0, m_valid}, 32'd1);
    check_idx_frame();
    take(0);
    chk("nom_cnt", {16'd0, frame_cnt}, 32'd1);
    chk("nom_ready_back", {31'd0, s_ready}, 32'd1);

    // Backpressure with beats offered while holding
    send_rec(LEN, LEN - 1, 0, 1);
    s_valid = 1'b1;
    repeat (50) begin s_data = 8'($urandom); @(posedge clk); #1; end
    s_valid = 1'b0;
    chk("bp_hold", {31'd0, m_valid}, 32'd1);
    take(0);
    send_rec(LEN, LEN - 1, 0, 1);
    take(3);

    // Short record then full record
    e0 = errs;
    send_rec(101, 100, 0, 1);
    repeat (2) @(posedge clk); #1;
    chk("short_err", errs - e0, 1);
    chk("short_no_frame", {31'd0, m_valid}, 32'd0);
    send_rec(LEN, LEN - 1, 0, 1);
    take(1);

    // Long record then full record
    e0 = errs;
    send_rec(300, 299, 0, 1);
    repeat (2) @(posedge clk); #1;
    chk("long_err", errs - e0, 1);
    chk("long_no_frame", {31'd0, m_valid}, 32'd0);
    send_rec(LEN, LEN - 1, 0, 1);
    take(0);

    // Sparse valid, data = index
    send_rec(LEN, LEN - 1, 1, 0);
    check_idx_frame();
    take(2);

    // Reset mid-record
    e0 = errs;
    send_rec(150, -1, 0, 1);
    s_valid = 1'b1; rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rstmid_cnt", {16'd0, frame_cnt}, 32'd0);
    rst = 1'b0; s_valid = 1'b0;
    send_rec(LEN, LEN - 1, 0, 0);
    check_idx_frame();
    take(0);
    chk("rstmid_no_err", errs - e0, 0);
    chk("rstmid_cnt1", {16'd0, frame_cnt}, 32'd1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
